agu_arbiter: RTL and testbench

AGU_ARBITER -- requirements
Module: agu_arbiter

---
 rtl/agu_arbiter_pkg.sv | 30 +++
 rtl/agu_arbiter_addr_gen.sv | 18 +
 rtl/agu_arbiter.sv | 102 ++++++++++
 tb/tb_agu_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/agu_arbiter_pkg.sv
// Shared types for the AGU arbiter: tag, register data and memory-op encodings,
// plus the size-based alignment rule used by the address-generation datapath.
package agu_arbiter_pkg;

  localparam int AGU_TAG_W  = 6;
  localparam int REG_DATA_W = 32;

  typedef logic [AGU_TAG_W-1:0]  agu_tag_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    OP_MEM_NONE = 2'd0,
    OP_MEM_LD   = 2'd1,
    OP_MEM_LDU  = 2'd2,
    OP_MEM_ST   = 2'd3
  } decode_mem_op_t;

  // size is log2 of the access width in bytes
  function automatic logic is_misaligned(input reg_data_t addr, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = addr[0];
      2'd2:    mis = |addr[1:0];
      default: mis = |addr[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/agu_arbiter_addr_gen.sv
// Address-generation datapath: wrapping base+offset, alignment check and load decode.
module addr_gen_unit
  import agu_arbiter_pkg::*;
(
  input  reg_data_t      src1,
  input  reg_data_t      offset,
  input  logic [1:0]     size,
  input  decode_mem_op_t op,
  output reg_data_t      addr,
  output logic           misalign,
  output logic           is_ld
);

  assign addr     = src1 + offset;
  assign misalign = is_misaligned(addr, size);
  assign is_ld    = (op == OP_MEM_LD) || (op == OP_MEM_LDU);

endmodule

// File: rtl/agu_arbiter.sv
// Round-robin arbiter sharing one address-generation path between the load and
// store queues, with a single registered output stage and full throughput.
module agu_arbiter
  import agu_arbiter_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [31:0]    i_log_fd,
  input  logic           i_flush,
  input  logic           i_ld_valid,
  output logic           o_ld_ready,
  input  decode_mem_op_t i_ld_op,
  input  reg_data_t      i_ld_src1,
  input  reg_data_t      i_ld_offset,
  input  logic [1:0]     i_ld_size,
  input  agu_tag_t       i_ld_tag,
  input  logic           i_st_valid,
  output logic           o_st_ready,
  input  decode_mem_op_t i_st_op,
  input  reg_data_t      i_st_src1,
  input  reg_data_t      i_st_offset,
  input  logic [1:0]     i_st_size,
  input  agu_tag_t       i_st_tag,
  output logic           o_valid,
  input  logic           i_ready,
  output reg_data_t      o_addr,
  output logic           o_ld,
  output logic           o_misalign,
  output agu_tag_t       o_tag,
  output logic           o_port
);

  logic           advance;
  logic           grant_st;
  logic           xfer;
  logic           rr;
  reg_data_t      sel_src1;
  reg_data_t      sel_offset;
  logic [1:0]     sel_size;
  decode_mem_op_t sel_op;
  agu_tag_t       sel_tag;
  reg_data_t      gen_addr;
  logic           gen_misalign;
  logic           gen_ld;

  // rr names the preferred port only when both queues are requesting
  always_comb begin
    advance    = (!o_valid || i_ready) && !i_flush;
    grant_st   = i_st_valid && (!i_ld_valid || rr);
    o_ld_ready = !i_rst && advance && i_ld_valid && !grant_st;
    o_st_ready = !i_rst && advance && grant_st;
    xfer       = o_ld_ready || o_st_ready;
  end

  assign sel_src1   = grant_st ? i_st_src1   : i_ld_src1;
  assign sel_offset = grant_st ? i_st_offset : i_ld_offset;
  assign sel_size   = grant_st ? i_st_size   : i_ld_size;
  assign sel_op     = grant_st ? i_st_op     : i_ld_op;
  assign sel_tag    = grant_st ? i_st_tag    : i_ld_tag;

  addr_gen_unit u_addr_gen (
    .src1     (sel_src1),
    .offset   (sel_offset),
    .size     (sel_size),
    .op       (sel_op),
    .addr     (gen_addr),
    .misalign (gen_misalign),
    .is_ld    (gen_ld)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      rr         <= 1'b0;
      o_addr     <= '0;
      o_ld       <= 1'b0;
      o_misalign <= 1'b0;
      o_tag      <= '0;
      o_port     <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (xfer) begin
      o_valid    <= 1'b1;
      rr         <= ~grant_st;
      o_addr     <= gen_addr;
      o_ld       <= gen_ld;
      o_misalign <= gen_misalign;
      o_tag      <= sel_tag;
      o_port     <= grant_st;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (xfer && i_log_fd != 32'd0)
      $display("agu: port=%0d tag=%0d addr=%08h", grant_st, sel_tag, gen_addr);
  end
`endif

endmodule

// File: tb/tb_agu_arbiter.sv
// Scoreboard bench for agu_arbiter: predicts grants, handshakes and results from
// the driven stimulus and compares them against the registered outputs.
module tb_agu_arbiter;
  import agu_arbiter_pkg::*;

  typedef struct packed {
    reg_data_t addr;
    logic      ld;
    logic      mis;
    agu_tag_t  tag;
    logic      port;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    log_fd = 32'd0;
  logic           flush = 1'b0;
  logic           ld_valid = 1'b0, st_valid = 1'b0, ready = 1'b0;
  logic           ld_ready, st_ready;
  decode_mem_op_t ld_op = OP_MEM_LD, st_op = OP_MEM_ST;
  reg_data_t      ld_src1 = '0, ld_offset = '0, st_src1 = '0, st_offset = '0;
  logic [1:0]     ld_size = '0, st_size = '0;
  agu_tag_t       ld_tag = '0, st_tag = '0;
  logic           o_valid, o_ld, o_misalign, o_port;
  reg_data_t      o_addr;
  agu_tag_t       o_tag;

  int   num_checks = 0;
  int   num_errors = 0;
  exp_t exp_q[$];
  exp_t cur_exp = '0;
  logic m_valid = 1'b0;
  logic m_rr = 1'b0;

  always #5 clk = ~clk;

  agu_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_log_fd(log_fd), .i_flush(flush),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_op(ld_op), .i_st_op(st_op),
    .i_ld_src1(ld_src1), .i_st_src1(st_src1),
    .i_ld_offset(ld_offset), .i_st_offset(st_offset),
    .i_ld_size(ld_size), .i_st_size(st_size),
    .i_ld_tag(ld_tag), .i_st_tag(st_tag),
    .i_st_valid(st_valid), .o_st_ready(st_ready),
    .o_valid(o_valid), .i_ready(ready),
    .o_addr(o_addr), .o_ld(o_ld), .o_misalign(o_misalign),
    .o_tag(o_tag), .o_port(o_port)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic exp_t predict(input logic port);
    exp_t           e;
    reg_data_t      s, o;
    logic [1:0]     sz;
    decode_mem_op_t op;
    if (port) begin
      s = st_src1; o = st_offset; sz = st_size; op = st_op; e.tag = st_tag;
    end else begin
      s = ld_src1; o = ld_offset; sz = ld_size; op = ld_op; e.tag = ld_tag;
    end
    e.addr = s + o;
    case (sz)
      2'd0:    e.mis = 1'b0;
      2'd1:    e.mis = e.addr[0];
      2'd2:    e.mis = e.addr[1] | e.addr[0];
      default: e.mis = e.addr[2] | e.addr[1] | e.addr[0];
    endcase
    e.ld   = (op == OP_MEM_LD) || (op == OP_MEM_LDU);
    e.port = port;
    return e;
  endfunction

  task automatic setLd(input reg_data_t s, input reg_data_t o, input logic [1:0] sz,
                       input agu_tag_t t, input decode_mem_op_t op);
    ld_src1 = s; ld_offset = o; ld_size = sz; ld_tag = t; ld_op = op;
  endtask

  task automatic setSt(input reg_data_t s, input reg_data_t o, input logic [1:0] sz,
                       input agu_tag_t t, input decode_mem_op_t op);
    st_src1 = s; st_offset = o; st_size = sz; st_tag = t; st_op = op;
  endtask

  // One clock of stimulus: predict readies before the edge, results after it
  task automatic applyStimulus(input logic ldv, input logic stv, input logic rdy, input logic fl);
    logic adv, gst, exp_ldr, exp_str;
    @(negedge clk);
    ld_valid = ldv; st_valid = stv; ready = rdy; flush = fl;
    #1;
    adv     = (!m_valid || rdy) && !fl;
    gst     = stv && (!ldv || m_rr);
    exp_ldr = adv && ldv && !gst;
    exp_str = adv && stv && gst;
    checkOutput("ld_ready", {31'd0, ld_ready}, {31'd0, exp_ldr});
    checkOutput("st_ready", {31'd0, st_ready}, {31'd0, exp_str});
    if (exp_ldr || exp_str) exp_q.push_back(predict(gst));
    @(posedge clk);
    #1;
    if (fl) m_valid = 1'b0;
    else if (exp_ldr || exp_str) begin
      m_valid = 1'b1;
      m_rr    = ~gst;
      if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    end else if (rdy) m_valid = 1'b0;
    checkOutput("o_valid", {31'd0, o_valid}, {31'd0, m_valid});
    if (m_valid) begin
      checkOutput("o_addr", o_addr, cur_exp.addr);
      checkOutput("o_ld", {31'd0, o_ld}, {31'd0, cur_exp.ld});
      checkOutput("o_misalign", {31'd0, o_misalign}, {31'd0, cur_exp.mis});
      checkOutput("o_tag", {26'd0, o_tag}, {26'd0, cur_exp.tag});
      checkOutput("o_port", {31'd0, o_port}, {31'd0, cur_exp.port});
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b1; st_valid = 1'b1; ready = 1'b0; flush = 1'b0;
    #1;
    checkOutput("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("rst_st_ready", {31'd0, st_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_addr", o_addr, 32'd0);
    checkOutput("rst_ld", {31'd0, o_ld}, 32'd0);
    checkOutput("rst_mis", {31'd0, o_misalign}, 32'd0);
    checkOutput("rst_tag", {26'd0, o_tag}, 32'd0);
    checkOutput("rst_port", {31'd0, o_port}, 32'd0);
    @(negedge clk);
    rst = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
    m_valid = 1'b0; m_rr = 1'b0; cur_exp = '0;
    exp_q.delete();
  endtask

  initial begin
    logic port_before;
    doReset();

    // Single load
    setLd(32'h1000, 32'h10, 2'd2, 6'd5, OP_MEM_LD);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("req021_addr", o_addr, 32'h1010);
    checkOutput("req021_valid", {31'd0, o_valid}, 32'd1);
    checkOutput("req021_tag", {26'd0, o_tag}, 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Misaligned store
    setSt(32'h2001, 32'h2, 2'd1, 6'd9, OP_MEM_ST);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("req023_addr", o_addr, 32'h2003);
    checkOutput("req023_mis", {31'd0, o_misalign}, 32'd1);
    checkOutput("req023_port", {31'd0, o_port}, 32'd1);

    // Wrapping address
    setLd(32'hFFFF_FFFC, 32'h8, 2'd3, 6'd3, OP_MEM_LDU);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("req026_addr", o_addr, 32'h0000_0004);
    checkOutput("req026_mis", {31'd0, o_misalign}, 32'd1);

    // Alternating grants from reset
    doReset();
    setLd(32'h100, 32'h4, 2'd2, 6'd1, OP_MEM_LD);
    setSt(32'h200, 32'h8, 2'd3, 6'd2, OP_MEM_ST);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("alt_port", {31'd0, o_port}, i % 2);
    end

    // Stall with both ports requesting, then release
    port_before = o_port;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("stall_next_port", {31'd0, o_port}, {31'd0, ~port_before});

    // Flush while holding a result with a pending load
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_valid", {31'd0, o_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 300; i++) begin
      setLd($urandom, $urandom_range(0, 64), 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), decode_mem_op_t'(2'($urandom_range(0, 3))));
      setSt($urandom, $urandom_range(0, 64), 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), decode_mem_op_t'(2'($urandom_range(0, 3))));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    // Reset during a stall drops the held result
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_port", {31'd0, o_port}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
